note_duration_timer: RTL and testbench

//  Parametrised note-length timer for the music path. Accepts note-length codes over
//  a valid/ready handshake and times each note against a programmable tempo (cycles per

---
 rtl/note_duration_timer_if.sv | 22 ++
 rtl/note_duration_timer.sv | 169 ++++++++++++++++
 tb/tb_note_duration_timer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/note_duration_timer_if.sv
// Note request handshake between the melody sequencer and the note timer.
// The sequencer is the master; the timer is the slave.
interface note_duration_timer_if;
    logic       len_valid;
    logic       len_ready;
    logic [3:0] len_code;
    logic       len_rest;

    modport master (
        output len_valid,
        output len_code,
        output len_rest,
        input  len_ready
    );

    modport slave (
        input  len_valid,
        input  len_code,
        input  len_rest,
        output len_ready
    );
endinterface

// File: rtl/note_duration_timer.sv
// Note-length timer: times each accepted note against a programmable tempo.
// Optional articulation gap enabled by defining NOTE_TIMER_GAP_EN.
module note_duration_timer #(
    parameter int BEAT_W     = 26,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BEAT_W-1:0]     beat_cycles,
    note_duration_timer_if.slave  len,
    input  logic                  pause,
    output logic                  gate,
    output logic                  note_done,
    output logic                  busy,
    output logic                  bad_len
);

    localparam int CW = BEAT_W + 2;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] q;
    logic [CW-1:0] dur;
    logic [CW-1:0] dur_m1;
    logic          tone;
    logic          bad;
    logic          gate_en;
    logic          cnt_zero;
    logic          can_take;
    logic          accept;
    logic          tone_on;

    assign q        = CW'(beat_cycles);
    assign dur_m1   = dur - CW'(1);
    assign cnt_zero = (cnt == '0);
    // In IDLE the counter is always zero, so one term covers both states.
    assign can_take = (state == IDLE) | (cnt_zero & ~pause);
    assign accept   = len.len_valid & can_take;

    // Decode the length code into a duration using shifts and adds only.
    always_comb begin
        dur  = CW'(1);
        tone = 1'b0;
        bad  = 1'b0;
        unique case (len.len_code)
            4'd1: begin dur = q << 2;              tone = 1'b1; end
            4'd2: begin dur = q << 1;              tone = 1'b1; end
            4'd3: begin dur = q;                   tone = 1'b1; end
            4'd4: begin dur = q >> 1;              tone = 1'b1; end
            4'd5: begin dur = (q << 1) + q;        tone = 1'b1; end
            4'd6: begin dur = q + (q >> 1);        tone = 1'b1; end
            4'd7: begin dur = (q >> 1) + (q >> 2); tone = 1'b1; end
            4'd8: begin dur = q >> 2;              tone = 1'b1; end
            4'd0: dur = CW'(1);
            default: begin
                dur = CW'(1);
                bad = 1'b1;
            end
        endcase
        if (dur == '0) begin
            dur = CW'(1);
        end
    end

`ifdef NOTE_TIMER_GAP_EN
    localparam logic [CW-1:0] GAP_MAX = CW'(GAP_CYCLES);

    logic [CW-1:0] gap_len;
    logic [CW-1:0] gap_nx;

    // Gap never swallows the whole note: at least one gated cycle remains.
    assign gap_nx  = (dur_m1 < GAP_MAX) ? dur_m1 : GAP_MAX;
    // Counter ends at zero, so the last gap_len cycles have cnt < gap_len.
    assign tone_on = (cnt >= gap_len);

    // Latch the gap length for the note being accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_len <= '0;
        end else if (accept) begin
            gap_len <= gap_nx;
        end
    end
`else
    // Gap length has no effect without the articulation gap.
    localparam int unused_gap_cycles = GAP_CYCLES;

    assign tone_on = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: leave RUN only on an unpaused final cycle with no new note.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt_zero && !pause && !accept) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state, counter and pause.
    always_comb begin
        len.len_ready = can_take;
        busy          = 1'b0;
        note_done     = 1'b0;
        gate          = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            RUN: begin
                busy      = 1'b1;
                note_done = cnt_zero & ~pause;
                gate      = gate_en & tone_on;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Down-counter: loads D-1 on accept, holds while paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= dur_m1;
        end else if (state == RUN && !pause && !cnt_zero) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Per-note gate enable and the sticky illegal-code flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_en <= 1'b0;
            bad_len <= 1'b0;
        end else if (accept) begin
            gate_en <= tone & ~len.len_rest;
            if (bad) begin
                bad_len <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_note_duration_timer.sv
// Scoreboard bench for note_duration_timer.
// Gap expectations follow NOTE_TIMER_GAP_EN with GAP_CYCLES=2.
module tb_note_duration_timer;

    localparam int BW  = 26;
    localparam int GAP = 2;
`ifdef NOTE_TIMER_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    typedef struct {
        int done_cyc;
        int gate_n;
        int busy_n;
        bit bad;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] beat;
    logic          pause;
    logic          gate;
    logic          note_done;
    logic          busy;
    logic          bad_len;

    note_duration_timer_if lif();

    note_duration_timer #(
        .BEAT_W    (BW),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .beat_cycles(beat),
        .len        (lif.slave),
        .pause      (pause),
        .gate       (gate),
        .note_done  (note_done),
        .busy       (busy),
        .bad_len    (bad_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    exp_t e;
    int   npass = 0;
    int   ntot  = 0;
    int   gacc  = 0;
    int   bacc  = 0;

    task automatic check(input string name, input longint act,
                         input longint want);
        ntot++;
        if (act == want) npass++;
        else $display("FAIL %s: got %0d want %0d", name, act, want);
    endtask

    // Monitor: counts gate/busy cycles per note and scores each note_done.
    always @(negedge clk) begin
        if (rst) begin
            gacc = 0;
            bacc = 0;
        end else begin
            if (busy) bacc++;
            if (gate) gacc++;
            if (note_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", cyc, -1);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("gate_cycles", gacc, e.gate_n);
                    check("busy_cycles", bacc, e.busy_n);
                    check("bad_len", bad_len, e.bad);
                    check("ready_at_done", lif.len_ready, 1);
                end
                gacc = 0;
                bacc = 0;
            end
        end
    end

    // Present one note; push its expected outcome when it is accepted.
    task automatic send(input logic [3:0] code, input bit rest,
                        input logic [BW-1:0] q, input int off,
                        input int g0, input int g1, input bit bad,
                        input bit push, output int t);
        int n = 0;
        beat          = q;
        lif.len_valid = 1'b1;
        lif.len_code  = code;
        lif.len_rest  = rest;
        @(negedge clk);
        while (!lif.len_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("accept_timeout", n, 0);
        t = cyc;
        if (push)
            sb.push_back(exp_t'{t + off, GAP_ON ? g1 : g0, off, bad});
        @(posedge clk);
        #1;
        lif.len_valid = 1'b0;
        lif.len_code  = 4'($urandom);
        lif.len_rest  = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("drain", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int t1, t2, t;

    initial begin
        rst           = 1'b1;
        pause         = 1'b0;
        beat          = BW'(8);
        lif.len_valid = 1'b0;
        lif.len_code  = 4'd0;
        lif.len_rest  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", lif.len_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_gate", gate, 0);
        check("rst_done", note_done, 0);
        check("rst_bad", bad_len, 0);
        @(posedge clk);
        #1;

        // Single quarter note, then quarter + eighth chained.
        send(4'd3, 0, 8, 8, 8, 6, 0, 1, t);
        drain();
        send(4'd3, 0, 8, 8, 8, 6, 0, 1, t1);
        send(4'd4, 0, 8, 4, 4, 2, 0, 1, t2);
        check("chain_accept", t2 - t1, 8);
        drain();

        // Duration table and clamping.
        send(4'd7, 0, 8, 6, 6, 4, 0, 1, t);
        send(4'd4, 0, 1, 1, 1, 1, 0, 1, t);
        send(4'd8, 0, 8, 2, 2, 1, 0, 1, t);
        send(4'd1, 0, 3, 12, 12, 10, 0, 1, t);
        send(4'd2, 0, 5, 10, 10, 8, 0, 1, t);
        send(4'd5, 0, 3, 9, 9, 7, 0, 1, t);
        send(4'd6, 0, 8, 12, 12, 10, 0, 1, t);
        send(4'd4, 0, 3, 1, 1, 1, 0, 1, t);
        send(4'd7, 0, 1, 1, 1, 1, 0, 1, t);
        drain();

        // Pause mid-note, then pause on the final cycle.
        send(4'd3, 0, 8, 11, 11, 9, 0, 1, t);
        repeat (2) @(posedge clk);
        #1 pause = 1'b1;
        repeat (3) @(posedge clk);
        #1 pause = 1'b0;
        drain();
        send(4'd3, 0, 8, 10, 10, 6, 0, 1, t);
        repeat (7) @(posedge clk);
        #1 pause = 1'b1;
        repeat (2) @(posedge clk);
        #1 pause = 1'b0;
        drain();
        pause = 1'b1;
        @(negedge clk);
        check("idle_pause_ready", lif.len_ready, 1);
        @(posedge clk);
        #1 pause = 1'b0;

        // Empty code, illegal code, rest.
        send(4'd0, 0, 8, 1, 0, 0, 0, 1, t);
        send(4'd12, 0, 8, 1, 0, 0, 1, 1, t);
        send(4'd3, 1, 8, 8, 0, 0, 1, 1, t);
        drain();

        // Reset mid-note: no note_done, flags cleared.
        send(4'd3, 0, 8, 8, 8, 6, 0, 0, t);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_cycle", cyc, t + 5);
        check("midrst_gate", gate, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", lif.len_ready, 1);
        check("midrst_bad", bad_len, 0);
        repeat (12) @(posedge clk);
        #1;

        // Tempo change during a note is ignored.
        send(4'd3, 0, 8, 8, 8, 6, 0, 1, t);
        beat = BW'(2);
        drain();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
